// File: rtl/fill_span_writer.sv
// fill_span_writer
// Writes one horizontal span of pixels (one scanline, x_lo..x_hi, clipped to
// the screen width) into the frame buffer over a req/ack write port, then
// pulses fill_done and waits for the controller to drop fill_start.
// Optional feature: define FILL_PIXEL_COUNT_EN to add the pixel_count output,
// which counts acknowledged writes in the current span.
module fill_span_writer #(
    parameter int X_W      = 10,
    parameter int Y_W      = 9,
    parameter int COLOR_W  = 8,
    parameter int ADDR_W   = 19,
    parameter int SCREEN_W = 640
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               fill_start,
    input  logic [Y_W-1:0]     y_row,
    input  logic [X_W-1:0]     x_left,
    input  logic [X_W-1:0]     x_right,
    input  logic [COLOR_W-1:0] color,
    input  logic               mem_ack,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [COLOR_W-1:0] mem_wdata,
    output logic               busy,
`ifdef FILL_PIXEL_COUNT_EN
    output logic [X_W-1:0]     pixel_count,
    output logic               fill_done
`else
    output logic               fill_done
`endif
);

    // Rightmost visible column; also the clip value for x_hi.
    localparam logic [X_W-1:0] X_MAX = X_W'(SCREEN_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WRITE,
        S_DONE,
        S_REARM
    } state_t;

    state_t               state_q, state_d;
    logic [Y_W-1:0]       y_q, y_d;
    logic [COLOR_W-1:0]   color_q, color_d;
    logic [X_W-1:0]       x_lo_q, x_lo_d;
    logic [X_W-1:0]       x_hi_q, x_hi_d;
    logic [X_W-1:0]       x_q, x_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic                 abort_q, abort_d;
`ifdef FILL_PIXEL_COUNT_EN
    logic [X_W-1:0]       pix_cnt_q, pix_cnt_d;
`endif

    // State register.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and output decode. An abort (fill_start low in LOAD/WRITE)
    // never cuts a pending write short: the beat finishes on ack first, and a
    // final ack always wins over an abort so the span reports completion.
    always_comb begin
        // NOTE: defaults first so every path assigns every output; no latches inferred.
        state_d   = state_q;
        mem_req   = 1'b0;
        busy      = 1'b0;
        fill_done = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (fill_start) state_d = S_LOAD;
            end
            S_LOAD: begin
                busy = 1'b1;
                if (!fill_start)         state_d = S_IDLE;
                else if (x_lo_q > X_MAX) state_d = S_DONE;
                else                     state_d = S_WRITE;
            end
            S_WRITE: begin
                busy    = 1'b1;
                mem_req = 1'b1;
                if (mem_ack) begin
                    if (x_q == x_hi_q)               state_d = S_DONE;
                    else if (abort_q || !fill_start) state_d = S_IDLE;
                end
            end
            S_DONE: begin
                busy      = 1'b1;
                fill_done = 1'b1;
                state_d   = S_REARM;
            end
            S_REARM: begin
                if (!fill_start) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next-state: latch the request, set up the first address, then
    // step x and the address together on every accepted write.
    always_comb begin
        y_d     = y_q;
        color_d = color_q;
        x_lo_d  = x_lo_q;
        x_hi_d  = x_hi_q;
        x_d     = x_q;
        addr_d  = addr_q;
        abort_d = abort_q;
`ifdef FILL_PIXEL_COUNT_EN
        pix_cnt_d = pix_cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (fill_start) begin
                    y_d     = y_row;
                    color_d = color;
                    x_lo_d  = (x_left <= x_right) ? x_left  : x_right;
                    x_hi_d  = (x_left <= x_right) ? x_right : x_left;
                end
            end
            S_LOAD: begin
                x_hi_d  = (x_hi_q > X_MAX) ? X_MAX : x_hi_q;
                abort_d = 1'b0;
`ifdef FILL_PIXEL_COUNT_EN
                pix_cnt_d = '0;
`endif
                if (x_lo_q <= X_MAX) begin
                    x_d    = x_lo_q;
                    addr_d = ADDR_W'(y_q) * ADDR_W'(SCREEN_W) + ADDR_W'(x_lo_q);
                end
            end
            S_WRITE: begin
                if (!fill_start) abort_d = 1'b1;
                if (mem_ack) begin
                    x_d    = x_q + X_W'(1);
                    addr_d = addr_q + ADDR_W'(1);
`ifdef FILL_PIXEL_COUNT_EN
                    pix_cnt_d = pix_cnt_q + X_W'(1);
`endif
                end
            end
            default: ;
        endcase
    end

    // Datapath registers, all cleared by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q     <= '0;
            color_q <= '0;
            x_lo_q  <= '0;
            x_hi_q  <= '0;
            x_q     <= '0;
            addr_q  <= '0;
            abort_q <= 1'b0;
`ifdef FILL_PIXEL_COUNT_EN
            pix_cnt_q <= '0;
`endif
        end else begin
            y_q     <= y_d;
            color_q <= color_d;
            x_lo_q  <= x_lo_d;
            x_hi_q  <= x_hi_d;
            x_q     <= x_d;
            addr_q  <= addr_d;
            abort_q <= abort_d;
`ifdef FILL_PIXEL_COUNT_EN
            pix_cnt_q <= pix_cnt_d;
`endif
        end
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = color_q;
`ifdef FILL_PIXEL_COUNT_EN
    assign pixel_count = pix_cnt_q;
`endif

endmodule

// File: tb/tb_fill_span_writer.sv
// Self-checking bench for fill_span_writer. A reference model pushes the
// expected frame-buffer writes into a scoreboard queue when a span is
// requested; a monitor pops and compares on every accepted write.
module tb_fill_span_writer;

    localparam int X_W      = 10;
    localparam int Y_W      = 9;
    localparam int COLOR_W  = 8;
    localparam int ADDR_W   = 19;
    localparam int SCREEN_W = 640;

    typedef struct packed {
        logic [ADDR_W-1:0]  addr;
        logic [COLOR_W-1:0] data;
    } wr_t;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               fill_start = 1'b0;
    logic [Y_W-1:0]     y_row = '0;
    logic [X_W-1:0]     x_left = '0;
    logic [X_W-1:0]     x_right = '0;
    logic [COLOR_W-1:0] color = '0;
    logic               mem_ack = 1'b0;
    logic               mem_req;
    logic [ADDR_W-1:0]  mem_addr;
    logic [COLOR_W-1:0] mem_wdata;
    logic               busy;
    logic               fill_done;
`ifdef FILL_PIXEL_COUNT_EN
    logic [X_W-1:0]     pixel_count;
`endif

    fill_span_writer #(
        .X_W(X_W), .Y_W(Y_W), .COLOR_W(COLOR_W), .ADDR_W(ADDR_W), .SCREEN_W(SCREEN_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .fill_start (fill_start),
        .y_row      (y_row),
        .x_left     (x_left),
        .x_right    (x_right),
        .color      (color),
        .mem_ack    (mem_ack),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .busy       (busy),
`ifdef FILL_PIXEL_COUNT_EN
        .pixel_count(pixel_count),
`endif
        .fill_done  (fill_done)
    );

    always #5 clk = ~clk;

    wr_t exp_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;
    int  cyc = 0;
    int  ack_mode = 0;        // 0: ack tied high, 1: three stall cycles per beat
    int  n_acks = 0;
    int  n_done = 0;
    int  n_req_cycles = 0;
    int  first_req_cyc = -1;
    int  last_ack_cyc = -1;
    int  done_cyc = -1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     tag, got, got, exp, exp, cyc);
        end
    endtask

    // Cycle counter, advanced on every active edge.
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Ack driver: updates shortly after each edge from the current mem_req.
    initial begin
        int stall_cnt;
        stall_cnt = 0;
        forever begin
            @(posedge clk);
            #2;
            if (ack_mode == 0) begin
                mem_ack = 1'b1;
                stall_cnt = 0;
            end else if (mem_req) begin
                if (stall_cnt == 3) begin
                    mem_ack = 1'b1;
                    stall_cnt = 0;
                end else begin
                    mem_ack = 1'b0;
                    stall_cnt++;
                end
            end else begin
                mem_ack = 1'b0;
                stall_cnt = 0;
            end
        end
    end

    // Monitor: samples mid-cycle, scores accepted writes and done pulses.
    initial begin
        logic               prev_stall;
        logic               prev_done;
        logic [ADDR_W-1:0]  prev_addr;
        logic [COLOR_W-1:0] prev_data;
        wr_t                e;
        prev_stall = 1'b0;
        prev_done  = 1'b0;
        prev_addr  = '0;
        prev_data  = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (prev_stall) begin
                    check("hold_req", mem_req, 1);
                    check("hold_addr", mem_addr, prev_addr);
                    check("hold_data", mem_wdata, prev_data);
                end
                if (mem_req) begin
                    n_req_cycles++;
                    if (first_req_cyc < 0) first_req_cyc = cyc;
                    check("busy_in_write", busy, 1);
                    if (mem_ack) begin
                        n_acks++;
                        last_ack_cyc = cyc;
                        check("write_expected", exp_q.size() > 0, 1);
                        if (exp_q.size() > 0) begin
                            e = exp_q.pop_front();
                            check("wr_addr", mem_addr, e.addr);
                            check("wr_data", mem_wdata, e.data);
                        end
                    end
                end
                if (fill_done) begin
                    n_done++;
                    done_cyc = cyc;
                    check("done_one_cycle", prev_done, 0);
                    check("busy_in_done", busy, 1);
                end
                prev_stall = mem_req && !mem_ack;
                prev_addr  = mem_addr;
                prev_data  = mem_wdata;
                prev_done  = fill_done;
            end else begin
                prev_stall = 1'b0;
                prev_done  = 1'b0;
            end
        end
    end

    // Reference model: push the expected writes for one span, return count.
    function automatic int model_span(input int y, input int xl, input int xr,
                                      input logic [COLOR_W-1:0] col);
        int lo, hi, n;
        lo = (xl < xr) ? xl : xr;
        hi = (xl < xr) ? xr : xl;
        if (hi > SCREEN_W - 1) hi = SCREEN_W - 1;
        n = 0;
        if (lo <= SCREEN_W - 1) begin
            for (int x = lo; x <= hi; x++) begin
                exp_q.push_back('{addr: ADDR_W'(y * SCREEN_W + x), data: col});
                n++;
            end
        end
        return n;
    endfunction

    task automatic start_span(input int y, input int xl, input int xr,
                              input logic [COLOR_W-1:0] col, output int start);
        @(posedge clk);
        #2;
        y_row      = Y_W'(y);
        x_left     = X_W'(xl);
        x_right    = X_W'(xr);
        color      = col;
        fill_start = 1'b1;
        start      = cyc;
    endtask

    // Full span: request, wait for done, optionally keep fill_start high for
    // `hold` cycles, then release and check counts and timing.
    task automatic run_span(input string tag, input int y, input int xl, input int xr,
                            input logic [COLOR_W-1:0] col, input int hold);
        int n, d0, a0, start, rq;
        n  = model_span(y, xl, xr, col);
        d0 = n_done;
        a0 = n_acks;
        first_req_cyc = -1;
        start_span(y, xl, xr, col, start);
        for (int i = 0; i < 400 && n_done == d0; i++) @(negedge clk);
        rq = n_req_cycles;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, "_rearm_busy"}, busy, 0);
        end
        check({tag, "_no_req_while_held"}, n_req_cycles - rq, 0);
        check({tag, "_done_count"}, n_done - d0, 1);
        check({tag, "_writes"}, n_acks - a0, n);
        check({tag, "_queue_empty"}, exp_q.size(), 0);
        if (n == 0) begin
            check({tag, "_no_req"}, first_req_cyc, -1);
            check({tag, "_done_latency"}, done_cyc - start, 2);
        end else begin
            check({tag, "_req_latency"}, first_req_cyc - start, 2);
            check({tag, "_done_after_ack"}, done_cyc - last_ack_cyc, 1);
            if (ack_mode == 0) check({tag, "_back_to_back"}, last_ack_cyc - first_req_cyc, n - 1);
        end
`ifdef FILL_PIXEL_COUNT_EN
        check({tag, "_pixel_count"}, pixel_count, n);
`endif
        @(posedge clk);
        #2;
        fill_start = 1'b0;
        repeat (2) @(negedge clk);
        check({tag, "_idle_busy"}, busy, 0);
        exp_q.delete();
    endtask

    // Watchdog: the run must never hang.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d compared / %0d mismatched", n_cmp, n_bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int start, a0, d0, a1;

        // Reset state.
        @(posedge clk);
        #1;
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_busy", busy, 0);
        check("rst_fill_done", fill_done, 0);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;

        run_span("basic",     2,   5,   8, 8'hA5, 0);
        run_span("swapped",   2,   8,   5, 8'h5A, 0);
        run_span("clip",      0, 630, 700, 8'hC3, 0);
        run_span("offscreen", 0, 650, 700, 8'h11, 0);
        run_span("single",    7,   7,   7, 8'hEE, 0);

        ack_mode = 1;
        run_span("stall",     1,  10,  13, 8'h77, 0);
        ack_mode = 0;

        run_span("rearm",     5,   0,   2, 8'h99, 5);
        run_span("rearm2",    5,   3,   4, 8'h98, 0);

        // Abort: drop fill_start while the second beat is stalled.
        ack_mode = 1;
        void'(model_span(3, 0, 9, 8'h3C));
        a0 = n_acks;
        d0 = n_done;
        start_span(3, 0, 9, 8'h3C, start);
        for (int i = 0; i < 200 && n_acks == a0; i++) @(negedge clk);
        @(posedge clk);
        #2;
        fill_start = 1'b0;
        repeat (20) @(negedge clk);
        check("abort_acks", n_acks - a0, 2);
        check("abort_no_done", n_done - d0, 0);
        check("abort_busy", busy, 0);
        check("abort_req", mem_req, 0);
        check("abort_unwritten", exp_q.size(), 8);
        exp_q.delete();
        ack_mode = 0;

        // Reset in the middle of a span.
        void'(model_span(4, 0, 20, 8'h42));
        a0 = n_acks;
        d0 = n_done;
        start_span(4, 0, 20, 8'h42, start);
        for (int i = 0; i < 200 && (n_acks - a0) < 3; i++) @(negedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        fill_start = 1'b0;
        #1;
        check("midrst_mem_req", mem_req, 0);
        check("midrst_mem_addr", mem_addr, 0);
        check("midrst_mem_wdata", mem_wdata, 0);
        check("midrst_busy", busy, 0);
        check("midrst_fill_done", fill_done, 0);
        exp_q.delete();
        a1 = n_acks;
        @(posedge clk);
        #2;
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("midrst_no_writes", n_acks - a1, 0);
        check("midrst_no_done", n_done - d0, 0);

        run_span("after_rst", 6, 100, 103, 8'h0F, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
